pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the MIPS32 core. Drives the load-enable and flush (bubble-insert) controls of the four pipeline registers IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable. It resolves load-use hazards, taken-branch flushes, multi-cycle multiply/divide (MDU) occupancy and data-memory wait states. It sits beside the hazard/forwarding logic and feeds every pipeline register instance.

---
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and pipeline-register controls exchanged
// between the MIPS32 datapath (master) and the sequencing controller (slave).
interface pipe_ctrl_if;
    // Hazard / status information from the datapath
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_mdu_start;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       mem_stall_req;
    // Pipeline register controls from the controller
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       mdu_busy;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start,
               ex_rd, ex_mem_read, ex_branch_taken, mem_stall_req,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mdu_busy
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mdu_start,
               ex_rd, ex_mem_read, ex_branch_taken, mem_stall_req,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, mdu_busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the MIPS32 core.
// Resolves load-use stalls, taken-branch flushes, multi-cycle MDU occupancy
// and data-memory wait states by driving the pipeline register enables/flushes.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl #(
    parameter int MDU_LAT = 4,   // total EX cycles of a mult/div, 2..15
    parameter int CNT_W   = 16   // perf counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // Counter is loaded with MDU_LAT-1 so the wait state lasts MDU_LAT-1 cycles
    localparam logic [3:0] C_CNT_LOAD = 4'(MDU_LAT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_load_use;
    logic w_mdu_go;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_mdu_busy;

    // Load-use hazard detect; $0 is hard-wired zero so never a hazard
    always_comb begin
        w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                      (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    end

    // An MDU op only starts when the ID instruction actually advances normally
    always_comb begin
        w_mdu_go = (r_state == RUN) && !bus.mem_stall_req &&
                   !bus.ex_branch_taken && !w_load_use && bus.id_mdu_start;
    end

    // Prioritised control decode; reset gating makes outputs drop without a clock
    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_mdu_busy    = 1'b0;
        if (!rst_n) begin
            // everything held at zero
        end else if (bus.mem_stall_req) begin
            // full freeze; busy flag still reflects the FSM state
            w_mdu_busy = (r_state == MDU_WAIT);
        end else if (r_state == MDU_WAIT) begin
            // front end held, bubble into EX/MEM, older work drains
            w_memwb_en    = 1'b1;
            w_exmem_flush = 1'b1;
            w_mdu_busy    = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_idex_en    = 1'b1;
            w_exmem_en   = 1'b1;
            w_memwb_en   = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            // hold IF/ID and PC, bubble into ID/EX so the load reaches MEM
            w_idex_en    = 1'b1;
            w_exmem_en   = 1'b1;
            w_memwb_en   = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            w_pc_en    = 1'b1;
            w_ifid_en  = 1'b1;
            w_idex_en  = 1'b1;
            w_exmem_en = 1'b1;
            w_memwb_en = 1'b1;
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.mdu_busy    = w_mdu_busy;

    // MDU occupancy FSM; counts down regardless of memory wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mdu_go) begin
                        r_state <= MDU_WAIT;
                        r_cnt   <= C_CNT_LOAD;
                    end
                end
                MDU_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating count of cycles the PC was held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!w_pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating count of front-end flushes (taken branches)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (w_ifid_flush && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (MDU_LAT=4).
// Output vector order: {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, busy}
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [8:0] E_ZERO  = 9'b00000_000_0;
    localparam logic [8:0] E_RUN   = 9'b11111_000_0;
    localparam logic [8:0] E_BR    = 9'b11111_110_0;
    localparam logic [8:0] E_LU    = 9'b00111_010_0;
    localparam logic [8:0] E_MDU   = 9'b00001_001_1;
    localparam logic [8:0] E_MDUST = 9'b00000_000_1;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
    pipe_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    pipe_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mdu_busy};
    endfunction

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = outs();
        checks++;
        $display("t=%0t %s obs=%b exp=%b", $time, tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
        bus.id_mdu_start = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
        bus.ex_branch_taken = 1'b0; bus.mem_stall_req = 1'b0;
    endtask

    // advance to 1ns after the next posedge, then settle inputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        // Reset held: outputs zero even with a branch pending
        bus.ex_branch_taken = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", E_ZERO);
        idle();
        @(negedge clk) rst_n = 1'b1;
        step(); #1 chk("after_reset_run", E_RUN);

        // Load-use on rs
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
        #1 chk("loaduse_rs", E_LU);
        step(); idle(); #1 chk("loaduse_cleared", E_RUN);
        // $0 never stalls
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        #1 chk("loaduse_r0", E_RUN);
        // Load-use on rt
        step(); idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
        #1 chk("loaduse_rt", E_LU);
        bus.id_uses_rt = 1'b0;
        #1 chk("rt_not_used", E_RUN);
        bus.id_uses_rt = 1'b1; bus.ex_mem_read = 1'b0;
        #1 chk("not_a_load", E_RUN);

        // Branch beats load-use and MDU start
        step(); idle();
        bus.ex_branch_taken = 1'b1; bus.id_mdu_start = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs = 5'd3; bus.id_uses_rs = 1'b1;
        #1 chk("branch_prio", E_BR);
        step(); idle(); #1 chk("branch_stays_run", E_RUN);

        // MDU op: 3 busy cycles
        bus.id_mdu_start = 1'b1;
        #1 chk("mdu_issue", E_RUN);
        step(); idle(); #1 chk("mdu_wait1", E_MDU);
        step(); #1 chk("mdu_wait2", E_MDU);
        step(); #1 chk("mdu_wait3", E_MDU);
        step(); #1 chk("mdu_done", E_RUN);

        // MDU op with a memory stall in the 2nd wait cycle: duration unchanged
        bus.id_mdu_start = 1'b1;
        step(); idle(); #1 chk("mdus_wait1", E_MDU);
        step(); bus.mem_stall_req = 1'b1; #1 chk("mdus_wait2_stall", E_MDUST);
        step(); idle(); #1 chk("mdus_wait3", E_MDU);
        step(); #1 chk("mdus_done", E_RUN);

        // Memory stall in RUN freezes, and blocks an MDU start
        bus.mem_stall_req = 1'b1; bus.id_mdu_start = 1'b1; bus.ex_branch_taken = 1'b1;
        #1 chk("memstall_run", E_ZERO);
        step(); idle(); #1 chk("memstall_no_mdu", E_RUN);

        // Load-use suppresses MDU start
        bus.id_mdu_start = 1'b1;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
        #1 chk("loaduse_blocks_mdu", E_LU);
        step(); idle(); #1 chk("loaduse_no_mdu", E_RUN);

        // Asynchronous reset in MDU_WAIT
        bus.id_mdu_start = 1'b1;
        step(); idle(); #1 chk("mdu_before_rst", E_MDU);
        rst_n = 1'b0;
        #1 chk("async_rst_mdu", E_ZERO);
        @(negedge clk) rst_n = 1'b1;
        step(); #1 chk("rst_back_to_run", E_RUN);

`ifdef PIPE_CTRL_PERF_EN
        // Fresh counters, then load-use + branch + one MDU op
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4; bus.id_rs = 5'd4; bus.id_uses_rs = 1'b1;
        step(); idle(); bus.ex_branch_taken = 1'b1;
        step(); idle(); bus.id_mdu_start = 1'b1;
        step(); idle();
        step(); step(); step(); #1 chk("perf_mdu_done", E_RUN);
        checks++;
        $display("t=%0t perf stall_cnt=%0d flush_cnt=%0d exp 4 1", $time, stall_cnt, flush_cnt);
        assert (stall_cnt === 16'd4 && flush_cnt === 16'd1) else begin
            failures++;
            $error("FAIL perf_counts observed=%0d/%0d expected=4/1", stall_cnt, flush_cnt);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
